// File: rtl/clint_timer.sv
`default_nettype none
// ============================================================================
// Module      : clint_timer
// Description : Memory-mapped machine timer (mtime/mtimecmp) and software
//               interrupt (msip) with a single-outstanding request port.
// Revision    : 1.0 - initial release
// ============================================================================
module clint_timer #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [7:0]  req_wmask_i,
    output logic        hit_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        timer_int_o,
    output logic        soft_int_o
);

    localparam int unsigned    PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX    = PW'(TICK_DIV - 1);
    localparam logic [15:0]    OFF_MSIP     = 16'h0000;
    localparam logic [15:0]    OFF_MTIMECMP = 16'h4000;
    localparam logic [15:0]    OFF_MTIME    = 16'hBFF8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          resp_valid_q, resp_valid_d;
    logic [63:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic          timer_int_q, timer_int_d;
    logic          soft_int_q, soft_int_d;

    logic          accept;
    logic          tick;
    logic          do_write;
    logic [15:0]   offset;
    logic          sel_msip, sel_cmp, sel_mtime, mapped;
    logic [63:0]   rd_val;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  mask);
        logic [63:0] res;
        res = old_val;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign hit_o  = (req_addr_i[63:16] == BASE_ADDR[63:16]);
    assign offset = req_addr_i[15:0];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state and handshake outputs
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                accept      = req_valid_i;
                if (req_valid_i) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_msip  = (offset == OFF_MSIP);
        sel_cmp   = (offset == OFF_MTIMECMP);
        sel_mtime = (offset == OFF_MTIME);
        mapped    = sel_msip | sel_cmp | sel_mtime;
        rd_val    = 64'd0;
        if (sel_msip)  rd_val = {63'd0, msip_q};
        if (sel_cmp)   rd_val = mtimecmp_q;
        if (sel_mtime) rd_val = mtime_q;
    end

    always_comb begin
        tick         = (presc_q == PRESC_MAX);
        presc_d      = tick ? '0 : presc_q + 1'b1;
        mtime_d      = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d   = mtimecmp_q;
        msip_d       = msip_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        timer_int_d  = (mtime_q >= mtimecmp_q);
        soft_int_d   = msip_q;
        do_write     = accept && req_wen_i && (req_wmask_i != 8'd0);

        if (accept) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = req_wen_i ? 64'd0 : rd_val;
            resp_err_d   = ~mapped;
        end else if ((state_q == ST_RESP) && resp_ready_i) begin
            resp_valid_d = 1'b0;
            resp_rdata_d = 64'd0;
            resp_err_d   = 1'b0;
        end

        // A software write to mtime overrides that cycle's increment
        if (do_write && sel_mtime) mtime_d    = merge_bytes(mtime_q, req_wdata_i, req_wmask_i);
        if (do_write && sel_cmp)   mtimecmp_d = merge_bytes(mtimecmp_q, req_wdata_i, req_wmask_i);
        if (do_write && sel_msip && req_wmask_i[0]) msip_d = req_wdata_i[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_q      <= 64'd0;
            mtimecmp_q   <= {64{1'b1}};
            msip_q       <= 1'b0;
            presc_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
            timer_int_q  <= 1'b0;
            soft_int_q   <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            msip_q       <= msip_d;
            presc_q      <= presc_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            timer_int_q  <= timer_int_d;
            soft_int_q   <= soft_int_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign timer_int_o  = timer_int_q;
    assign soft_int_o   = soft_int_q;

endmodule
`default_nettype wire

// File: tb/tb_clint_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_clint_timer
// Description : Randomized bench for clint_timer; two instances (TICK_DIV 1
//               and 4) share stimulus and are compared to a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clint_timer;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = BASE;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_wmask = 8'd0;
    logic        resp_ready = 1'b0;

    logic        rdy [2];
    logic        hit [2];
    logic        rv  [2];
    logic [63:0] rdata [2];
    logic        err [2];
    logic        tint [2];
    logic        sint [2];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
        .req_wen_i(req_wen), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wmask_i(req_wmask), .hit_o(hit[0]), .resp_valid_o(rv[0]),
        .resp_ready_i(resp_ready), .resp_rdata_o(rdata[0]), .resp_err_o(err[0]),
        .timer_int_o(tint[0]), .soft_int_o(sint[0])
    );

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
        .req_wen_i(req_wen), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wmask_i(req_wmask), .hit_o(hit[1]), .resp_valid_o(rv[1]),
        .resp_ready_i(resp_ready), .resp_rdata_o(rdata[1]), .resp_err_o(err[1]),
        .timer_int_o(tint[1]), .soft_int_o(sint[1])
    );

    // Reference model state
    int unsigned td [2] = '{1, 4};
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp;
    logic        m_msip;
    logic        m_busy, m_rv, m_err, m_in_reset;
    logic [63:0] m_rdata [2];
    logic        m_tint [2];
    logic        m_sint;
    int unsigned m_edges;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [63:0] bytewrite(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  mask);
        logic [63:0] r;
        r = old_v;
        for (int b = 0; b < 8; b++)
            if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_read(input int i, input logic [15:0] off);
        if (off == 16'h0000) return {63'd0, m_msip};
        if (off == 16'h4000) return m_cmp;
        if (off == 16'hBFF8) return m_mtime[i];
        return 64'd0;
    endfunction

    // One clock edge: advance the model with the inputs present at the edge, then check
    task automatic cycle();
        logic        acc;
        logic        tk;
        logic [15:0] off;
        @(posedge clk);
        if (!rst_n) begin
            m_mtime    = '{64'd0, 64'd0};
            m_cmp      = {64{1'b1}};
            m_msip     = 1'b0;
            m_busy     = 1'b0;
            m_rv       = 1'b0;
            m_err      = 1'b0;
            m_rdata    = '{64'd0, 64'd0};
            m_tint     = '{1'b0, 1'b0};
            m_sint     = 1'b0;
            m_edges    = 0;
            m_in_reset = 1'b1;
        end else begin
            m_in_reset = 1'b0;
            acc = req_valid && !m_busy;
            off = req_addr[15:0];
            for (int i = 0; i < 2; i++) m_tint[i] = (m_mtime[i] >= m_cmp);
            m_sint = m_msip;
            if (acc) begin
                m_busy = 1'b1;
                m_rv   = 1'b1;
                m_err  = !(off == 16'h0000 || off == 16'h4000 || off == 16'hBFF8);
                for (int i = 0; i < 2; i++) m_rdata[i] = req_wen ? 64'd0 : model_read(i, off);
            end else if (m_busy && resp_ready) begin
                m_busy = 1'b0;
                m_rv   = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                tk = ((m_edges % td[i]) == td[i] - 1);
                if (acc && req_wen && off == 16'hBFF8 && req_wmask != 8'd0)
                    m_mtime[i] = bytewrite(m_mtime[i], req_wdata, req_wmask);
                else if (tk)
                    m_mtime[i] = m_mtime[i] + 64'd1;
            end
            if (acc && req_wen && off == 16'h4000) m_cmp = bytewrite(m_cmp, req_wdata, req_wmask);
            if (acc && req_wen && off == 16'h0000 && req_wmask[0]) m_msip = req_wdata[0];
            m_edges++;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("req_ready", rdy[i], !m_busy);
            chk("resp_valid", rv[i], m_rv);
            if (m_rv || m_in_reset) begin
                chk("resp_rdata", rdata[i], m_rdata[i]);
                chk("resp_err", err[i], m_err);
            end
            chk("timer_int", tint[i], m_tint[i]);
            chk("soft_int", sint[i], m_sint);
            chk("hit", hit[i], req_addr[63:16] == BASE[63:16]);
        end
    endtask

    task automatic access(input logic wen, input logic [15:0] off, input logic [63:0] wd,
                          input logic [7:0] wm, input int stall);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = BASE + {48'd0, off};
        req_wdata  = wd;
        req_wmask  = wm;
        resp_ready = 1'b0;
        cycle();
        req_valid = 1'b0;
        req_wdata = {$urandom, $urandom};
        repeat (stall) cycle();
        resp_ready = 1'b1;
        cycle();
        resp_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            resp_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        resp_ready = 1'b0;
    endtask

    // Reset asserted while a response is pending
    task automatic reset_in_resp(input logic [15:0] off);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = BASE + {48'd0, off};
        cycle();
        req_valid = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] off;
        repeat (3) cycle();
        rst_n = 1'b1;

        idle(10);
        access(1'b0, 16'hBFF8, 64'd0, 8'h00, 0);
        access(1'b0, 16'h4000, 64'd0, 8'h00, 0);

        req_addr = 64'd0;
        cycle();
        req_addr = BASE;

        access(1'b1, 16'hBFF8, 64'd0, 8'hFF, 0);
        idle(20);
        access(1'b0, 16'hBFF8, 64'd0, 8'h00, 0);

        access(1'b1, 16'hBFF8, 64'd90, 8'hFF, 0);
        access(1'b1, 16'h4000, 64'd100, 8'hFF, 0);
        idle(45);
        access(1'b1, 16'h4000, {64{1'b1}}, 8'hFF, 0);
        idle(3);

        access(1'b1, 16'hBFF8, 64'h1111_2222_0000_0000, 8'hFF, 0);
        access(1'b1, 16'hBFF8, 64'hAAAA_BBBB_1234_5678, 8'h0F, 0);
        access(1'b0, 16'hBFF8, 64'd0, 8'h00, 1);
        access(1'b1, 16'hBFF8, 64'h5555_5555_5555_5555, 8'h00, 0);

        access(1'b0, 16'h0008, 64'd0, 8'h00, 5);

        access(1'b1, 16'h4000, 64'd0, 8'hFF, 0);
        access(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0);
        idle(10);
        access(1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 0);
        access(1'b0, 16'h0000, 64'd0, 8'h00, 0);
        access(1'b1, 16'h0000, 64'd0, 8'hFE, 0);
        idle(2);

        reset_in_resp(16'hBFF8);
        idle(3);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: off = 16'h0000;
                1: off = 16'h4000;
                2: off = 16'hBFF8;
                default: begin
                    r   = $urandom;
                    off = {r[12:0], 3'b000};
                    if (off == 16'h0000 || off == 16'h4000 || off == 16'hBFF8) off = 16'h0010;
                end
            endcase
            if ($urandom_range(0, 29) == 0) begin
                reset_in_resp(off);
            end else begin
                r = $urandom;
                access(1'(r[0]), off, {$urandom, $urandom},
                       r[1] ? 8'hFF : 8'(r[15:8]), int'(r[18:16] % 4));
            end
            idle($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
